// File: rtl/lc3b_control.sv
// LC-3b multicycle control FSM: fetch/decode/execute sequencing.
// Outputs are registered from the next state, so they track the state.
module lc3b_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       ir11,
  input  logic       ir5,
  input  logic       ir4,
  input  logic       branch_enable,
  input  logic       mar0,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic [1:0] pcmux_sel,
  output logic       adjmux_sel,
  output logic       storemux_sel,
  output logic       destmux_sel,
  output logic [1:0] alumux_sel,
  output logic [3:0] aluop,
  output logic [1:0] marmux_sel,
  output logic [1:0] mdrmux_sel,
  output logic [2:0] regfilemux_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'ha;
  localparam logic [3:0] OP_STI  = 4'hb;
  localparam logic [3:0] OP_JMP  = 4'hc;
  localparam logic [3:0] OP_SHF  = 4'hd;
  localparam logic [3:0] OP_LEA  = 4'he;
  localparam logic [3:0] OP_TRAP = 4'hf;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_NOT  = 4'd2;
  localparam logic [3:0] ALU_PASS = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, S_SHF,
    BR_TAKEN, S_JMP, S_JSR, S_LEA,
    CALC_ADDR, LD_RD, LD_WB,
    LDI_RD1, LDI_MAR,
    ST_MDR, ST_WR, STI_RD1, STI_MAR,
    TRAP1, TRAP_RD, TRAP3
  } state_t;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic [1:0] pcmux_sel;
    logic       adjmux_sel;
    logic       storemux_sel;
    logic       destmux_sel;
    logic [1:0] alumux_sel;
    logic [3:0] aluop;
    logic [1:0] marmux_sel;
    logic [1:0] mdrmux_sel;
    logic [2:0] regfilemux_sel;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } ctl_t;

  state_t state_q, state_d, st;
  ctl_t   ctl_q, ctl_d;
  logic   byte_op;

  assign byte_op = (opcode == OP_LDB) || (opcode == OP_STB);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  if (mem_resp) state_d = FETCH3;
      FETCH3:  state_d = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_ADD:  state_d = S_ADD;
          OP_AND:  state_d = S_AND;
          OP_NOT:  state_d = S_NOT;
          OP_SHF:  state_d = S_SHF;
          OP_BR:   state_d = branch_enable ? BR_TAKEN : FETCH1;
          OP_JMP:  state_d = S_JMP;
          OP_JSR:  state_d = S_JSR;
          OP_LEA:  state_d = S_LEA;
          OP_TRAP: state_d = TRAP1;
          OP_LDR, OP_LDB, OP_LDI,
          OP_STR, OP_STB, OP_STI:
                   state_d = CALC_ADDR;
          default: state_d = FETCH1;
        endcase
      end
      CALC_ADDR: begin
        unique case (opcode)
          OP_LDI:         state_d = LDI_RD1;
          OP_STI:         state_d = STI_RD1;
          OP_STR, OP_STB: state_d = ST_MDR;
          default:        state_d = LD_RD;
        endcase
      end
      LD_RD:   if (mem_resp) state_d = LD_WB;
      LDI_RD1: if (mem_resp) state_d = LDI_MAR;
      LDI_MAR: state_d = LD_RD;
      STI_RD1: if (mem_resp) state_d = STI_MAR;
      STI_MAR: state_d = ST_MDR;
      ST_MDR:  state_d = ST_WR;
      ST_WR:   if (mem_resp) state_d = FETCH1;
      TRAP1:   state_d = TRAP_RD;
      TRAP_RD: if (mem_resp) state_d = TRAP3;
      default: state_d = FETCH1;
    endcase
  end

  // Decode the state being entered so the registered outputs line up with it.
  always_comb begin
    st = reset ? FETCH1 : state_d;
    ctl_d = '0;
    ctl_d.aluop = ALU_ADD;
    ctl_d.mem_byte_enable = 2'b11;
    unique case (st)
      FETCH1: begin
        ctl_d.load_mar = 1'b1;
        ctl_d.marmux_sel = 2'd1;
        ctl_d.load_pc = 1'b1;
      end
      FETCH2, LD_RD, LDI_RD1, STI_RD1, TRAP_RD: begin
        ctl_d.mem_read = 1'b1;
        ctl_d.load_mdr = 1'b1;
        ctl_d.mdrmux_sel = 2'd1;
      end
      FETCH3: ctl_d.load_ir = 1'b1;
      S_ADD, S_AND, S_NOT, S_SHF: begin
        ctl_d.load_regfile = 1'b1;
        ctl_d.load_cc = 1'b1;
        ctl_d.alumux_sel = {1'b0, ir5 & (st != S_NOT) & (st != S_SHF)};
        unique case (st)
          S_AND:   ctl_d.aluop = ALU_AND;
          S_NOT:   ctl_d.aluop = ALU_NOT;
          S_SHF:   ctl_d.aluop = ir4 ? (ir5 ? ALU_SRA : ALU_SRL) : ALU_SLL;
          default: ctl_d.aluop = ALU_ADD;
        endcase
      end
      BR_TAKEN: begin
        ctl_d.load_pc = 1'b1;
        ctl_d.pcmux_sel = 2'd1;
      end
      S_JMP: begin
        ctl_d.aluop = ALU_PASS;
        ctl_d.load_pc = 1'b1;
        ctl_d.pcmux_sel = 2'd2;
      end
      S_JSR: begin
        ctl_d.load_regfile = 1'b1;
        ctl_d.destmux_sel = 1'b1;
        ctl_d.regfilemux_sel = 3'd2;
        ctl_d.load_pc = 1'b1;
        ctl_d.adjmux_sel = ir11;
        ctl_d.pcmux_sel = ir11 ? 2'd1 : 2'd2;
        ctl_d.aluop = ir11 ? ALU_ADD : ALU_PASS;
      end
      S_LEA: begin
        ctl_d.load_regfile = 1'b1;
        ctl_d.regfilemux_sel = 3'd3;
        ctl_d.load_cc = 1'b1;
      end
      CALC_ADDR: begin
        ctl_d.load_mar = 1'b1;
        ctl_d.alumux_sel = byte_op ? 2'd3 : 2'd2;
      end
      LD_WB: begin
        ctl_d.load_regfile = 1'b1;
        ctl_d.load_cc = 1'b1;
        ctl_d.regfilemux_sel = (opcode == OP_LDB) ? 3'd4 : 3'd1;
      end
      LDI_MAR, STI_MAR: begin
        ctl_d.load_mar = 1'b1;
        ctl_d.marmux_sel = 2'd2;
      end
      ST_MDR: begin
        ctl_d.storemux_sel = 1'b1;
        ctl_d.aluop = ALU_PASS;
        ctl_d.load_mdr = 1'b1;
        ctl_d.mdrmux_sel = (opcode == OP_STB) ? 2'd2 : 2'd0;
      end
      ST_WR: begin
        ctl_d.mem_write = 1'b1;
        if (opcode == OP_STB)
          ctl_d.mem_byte_enable = mar0 ? 2'b10 : 2'b01;
      end
      TRAP1: begin
        ctl_d.load_regfile = 1'b1;
        ctl_d.destmux_sel = 1'b1;
        ctl_d.regfilemux_sel = 3'd2;
        ctl_d.load_mar = 1'b1;
        ctl_d.marmux_sel = 2'd3;
      end
      TRAP3: begin
        ctl_d.load_pc = 1'b1;
        ctl_d.pcmux_sel = 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
    ctl_q <= ctl_d;
  end

  assign load_pc         = ctl_q.load_pc;
  assign load_ir         = ctl_q.load_ir;
  assign load_regfile    = ctl_q.load_regfile;
  assign load_mar        = ctl_q.load_mar;
  assign load_mdr        = ctl_q.load_mdr;
  assign load_cc         = ctl_q.load_cc;
  assign pcmux_sel       = ctl_q.pcmux_sel;
  assign adjmux_sel      = ctl_q.adjmux_sel;
  assign storemux_sel    = ctl_q.storemux_sel;
  assign destmux_sel     = ctl_q.destmux_sel;
  assign alumux_sel      = ctl_q.alumux_sel;
  assign aluop           = ctl_q.aluop;
  assign marmux_sel      = ctl_q.marmux_sel;
  assign mdrmux_sel      = ctl_q.mdrmux_sel;
  assign regfilemux_sel  = ctl_q.regfilemux_sel;
  assign mem_read        = ctl_q.mem_read;
  assign mem_write       = ctl_q.mem_write;
  assign mem_byte_enable = ctl_q.mem_byte_enable;

endmodule

// File: tb/tb_lc3b_control.sv
// Bench for lc3b_control: cycle-count table, per-cycle model runs, reset case.
module tb_lc3b_control;

  localparam logic [3:0] A_ADD = 4'd0, A_AND = 4'd1, A_NOT = 4'd2,
                         A_PASS = 4'd3, A_SLL = 4'd4, A_SRL = 4'd5,
                         A_SRA = 4'd6;

  logic clk = 1'b0;
  logic reset, ir11, ir5, ir4, branch_enable, mar0, mem_resp;
  logic [3:0] opcode;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic [1:0] pcmux_sel, alumux_sel, marmux_sel, mdrmux_sel;
  logic adjmux_sel, storemux_sel, destmux_sel, mem_read, mem_write;
  logic [3:0] aluop;
  logic [2:0] regfilemux_sel;
  logic [1:0] mem_byte_enable;

  always #5 clk = ~clk;

  lc3b_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ir11(ir11), .ir5(ir5),
    .ir4(ir4), .branch_enable(branch_enable), .mar0(mar0),
    .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
    .load_regfile(load_regfile), .load_mar(load_mar),
    .load_mdr(load_mdr), .load_cc(load_cc), .pcmux_sel(pcmux_sel),
    .adjmux_sel(adjmux_sel), .storemux_sel(storemux_sel),
    .destmux_sel(destmux_sel), .alumux_sel(alumux_sel), .aluop(aluop),
    .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .regfilemux_sel(regfilemux_sel), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
  );

  typedef struct packed {
    logic ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_cc;
    logic [1:0] pcmux;
    logic adj, store, dest;
    logic [1:0] alumux;
    logic [3:0] aluop;
    logic [1:0] marmux, mdrmux;
    logic [2:0] rfmux;
    logic rd, wr;
    logic [1:0] be;
  } ctl_t;

  ctl_t act;
  always_comb act = {load_pc, load_ir, load_regfile, load_mar, load_mdr,
                     load_cc, pcmux_sel, adjmux_sel, storemux_sel,
                     destmux_sel, alumux_sel, aluop, marmux_sel,
                     mdrmux_sel, regfilemux_sel, mem_read, mem_write,
                     mem_byte_enable};

  int passed = 0;
  int total = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  // Reference model: list of expected control words, one per cycle.
  ctl_t exp_q[$];
  bit   resp_q[$];

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.aluop = A_ADD;
    c.be = 2'b11;
    return c;
  endfunction

  function automatic ctl_t f1_word();
    ctl_t c;
    c = idle();
    c.ld_mar = 1;
    c.marmux = 2'd1;
    c.ld_pc = 1;
    return c;
  endfunction

  function automatic ctl_t rd_word();
    ctl_t c;
    c = idle();
    c.rd = 1;
    c.ld_mdr = 1;
    c.mdrmux = 2'd1;
    return c;
  endfunction

  task automatic push(input ctl_t c);
    exp_q.push_back(c);
    resp_q.push_back(1'b0);
  endtask

  // Memory phase: word repeats for the wait cycles, resp on the last one.
  task automatic push_mem(input ctl_t c, input int w);
    int n;
    n = (w < 0) ? int'($urandom_range(0, 3)) : w;
    repeat (n) push(c);
    exp_q.push_back(c);
    resp_q.push_back(1'b1);
  endtask

  task automatic build(input logic [3:0] op, input logic i11, i5, i4,
                       input logic be_in, m0, input int w);
    ctl_t c;
    bit is_ld, is_st;
    push(f1_word());
    push_mem(rd_word(), w);
    c = idle(); c.ld_ir = 1; push(c);
    push(idle());
    is_ld = (op == 4'h2) || (op == 4'h6) || (op == 4'ha);
    is_st = (op == 4'h3) || (op == 4'h7) || (op == 4'hb);
    c = idle();
    if (op == 4'h1 || op == 4'h5 || op == 4'h9 || op == 4'hd) begin
      c.ld_rf = 1; c.ld_cc = 1;
      if (op == 4'h1) begin c.aluop = A_ADD; c.alumux = i5 ? 2'd1 : 2'd0; end
      if (op == 4'h5) begin c.aluop = A_AND; c.alumux = i5 ? 2'd1 : 2'd0; end
      if (op == 4'h9) c.aluop = A_NOT;
      if (op == 4'hd) c.aluop = !i4 ? A_SLL : (i5 ? A_SRA : A_SRL);
      push(c);
    end else if (op == 4'h0) begin
      if (be_in) begin c.ld_pc = 1; c.pcmux = 2'd1; push(c); end
    end else if (op == 4'hc) begin
      c.aluop = A_PASS; c.ld_pc = 1; c.pcmux = 2'd2; push(c);
    end else if (op == 4'h4) begin
      c.ld_rf = 1; c.dest = 1; c.rfmux = 3'd2; c.ld_pc = 1;
      c.adj = i11;
      c.pcmux = i11 ? 2'd1 : 2'd2;
      c.aluop = i11 ? A_ADD : A_PASS;
      push(c);
    end else if (op == 4'he) begin
      c.ld_rf = 1; c.rfmux = 3'd3; c.ld_cc = 1; push(c);
    end else if (is_ld || is_st) begin
      c.ld_mar = 1;
      c.alumux = (op == 4'h2 || op == 4'h3) ? 2'd3 : 2'd2;
      push(c);
      if (op == 4'ha || op == 4'hb) begin
        push_mem(rd_word(), w);
        c = idle(); c.ld_mar = 1; c.marmux = 2'd2; push(c);
      end
      if (is_ld) begin
        push_mem(rd_word(), w);
        c = idle(); c.ld_rf = 1; c.ld_cc = 1;
        c.rfmux = (op == 4'h2) ? 3'd4 : 3'd1;
        push(c);
      end else begin
        c = idle(); c.store = 1; c.aluop = A_PASS; c.ld_mdr = 1;
        c.mdrmux = (op == 4'h3) ? 2'd2 : 2'd0;
        push(c);
        c = idle(); c.wr = 1;
        if (op == 4'h3) c.be = m0 ? 2'b10 : 2'b01;
        push_mem(c, w);
      end
    end else if (op == 4'hf) begin
      c.ld_rf = 1; c.dest = 1; c.rfmux = 3'd2;
      c.ld_mar = 1; c.marmux = 2'd3;
      push(c);
      push_mem(rd_word(), w);
      c = idle(); c.ld_pc = 1; c.pcmux = 2'd3; push(c);
    end
  endtask

  // Apply one instruction starting at a FETCH1 cycle and compare every cycle.
  task automatic run(input logic [3:0] op, input logic i11, i5, i4,
                     input logic be_in, m0, input int w);
    exp_q.delete();
    resp_q.delete();
    opcode = op; ir11 = i11; ir5 = i5; ir4 = i4;
    branch_enable = be_in; mar0 = m0;
    build(op, i11, i5, i4, be_in, m0, w);
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("op%h cyc%0d", op, k), 32'(act), 32'(exp_q[k]));
      mem_resp = resp_q[k];
      @(negedge clk);
    end
    mem_resp = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic i11, i5, i4, be, m0;
    int cyc;
    int mem;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int cyc, memc;
    bit found;

    tbl[0]  = '{4'h1, 0, 1, 0, 0, 0, 5, 1};
    tbl[1]  = '{4'h5, 0, 0, 0, 0, 0, 5, 1};
    tbl[2]  = '{4'h9, 0, 0, 0, 0, 0, 5, 1};
    tbl[3]  = '{4'hd, 0, 1, 1, 0, 0, 5, 1};
    tbl[4]  = '{4'h0, 0, 0, 0, 0, 0, 4, 1};
    tbl[5]  = '{4'h0, 0, 0, 0, 1, 0, 5, 1};
    tbl[6]  = '{4'hc, 0, 0, 0, 0, 0, 5, 1};
    tbl[7]  = '{4'h4, 1, 0, 0, 0, 0, 5, 1};
    tbl[8]  = '{4'he, 0, 0, 0, 0, 0, 5, 1};
    tbl[9]  = '{4'h6, 0, 0, 0, 0, 0, 7, 2};
    tbl[10] = '{4'h2, 0, 0, 0, 0, 1, 7, 2};
    tbl[11] = '{4'ha, 0, 0, 0, 0, 0, 9, 3};
    tbl[12] = '{4'h7, 0, 0, 0, 0, 0, 7, 2};
    tbl[13] = '{4'h3, 0, 0, 0, 0, 1, 7, 2};
    tbl[14] = '{4'hb, 0, 0, 0, 0, 0, 9, 3};
    tbl[15] = '{4'hf, 0, 0, 0, 0, 0, 7, 2};
    tbl[16] = '{4'h8, 0, 0, 0, 0, 0, 4, 1};

    reset = 1; mem_resp = 0; opcode = 4'h1;
    ir11 = 0; ir5 = 0; ir4 = 0; branch_enable = 0; mar0 = 0;

    // Reset abandons a fetch read that is still waiting.
    repeat (2) @(negedge clk);
    reset = 0;
    check("reset_fetch1", 32'(act), 32'(f1_word()));
    @(negedge clk);
    check("fetch2_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("fetch2_hold", 32'(mem_read), 32'd1);
    reset = 1;
    @(negedge clk);
    check("reset_drop_read", 32'(mem_read), 32'd0);
    check("reset_mid_fetch1", 32'(act), 32'(f1_word()));
    @(negedge clk);
    reset = 0;
    check("reset_held_fetch1", 32'(act), 32'(f1_word()));

    // Instruction length and memory-cycle counts with zero wait states.
    mem_resp = 1;
    foreach (tbl[i]) begin
      opcode = tbl[i].op; ir11 = tbl[i].i11; ir5 = tbl[i].i5;
      ir4 = tbl[i].i4; branch_enable = tbl[i].be; mar0 = tbl[i].m0;
      cyc = 0; memc = 0; found = 0;
      for (int n = 0; n < 40 && !found; n++) begin
        if (mem_read || mem_write) memc++;
        @(negedge clk);
        cyc++;
        if (load_pc && load_mar && marmux_sel == 2'd1) found = 1;
      end
      check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("tbl%0d_memcyc", i), 32'(memc), 32'(tbl[i].mem));
    end
    mem_resp = 0;

    // Multi-cycle corner sequences.
    run(4'h1, 0, 1, 0, 0, 0, 3);
    run(4'h3, 0, 0, 0, 0, 1, 2);
    run(4'h3, 0, 0, 0, 0, 0, 1);
    run(4'ha, 0, 0, 0, 0, 0, 1);
    run(4'hf, 0, 0, 0, 0, 0, 2);
    run(4'h4, 0, 0, 0, 0, 0, 0);
    run(4'h0, 0, 0, 0, 0, 0, 0);
    run(4'h0, 0, 0, 0, 1, 0, 0);
    run(4'hb, 0, 0, 0, 0, 1, 0);

    // Random instruction stream with random memory latency.
    for (int n = 0; n < 150; n++) begin
      run(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
